// File: rtl/ser7_link_ctrl.sv
// ser7_link_ctrl
// Link sequencer for a 7:1 DDR serializer, clocked by the serializer's
// parallel clock. It holds the serializer in reset, then sends a training
// burst, then streams source words over a valid/ready handshake. It sends
// IDLE_WORD whenever no word is accepted.
//
// Optional feature: define SER7_LINK_RESYNC_EN to compile in the period
// counter and the RESYNC state. That state sends a 2-word training burst
// every RESYNC_PERIOD DATA cycles.
//
// Ports
//   i_clk        parallel clock (serializer pclk)
//   i_reset      asynchronous, active-high reset
//   i_enable     link enable; low forces RESET_HOLD
//   i_data[6:0]  source word
//   i_valid      source word valid
//   o_ready      word accepted this cycle (combinational)
//   o_din[6:0]   registered word to serializer din
//   o_ser_reset  registered serializer reset, active-high
//   o_trained    high in DATA and RESYNC
//   o_state[1:0] 0=RESET_HOLD 1=TRAIN 2=DATA 3=RESYNC
//   o_sent_cnt   accepted-word count, wraps
//
// state       | meaning
// ------------+----------------------------------------------------
// RESET_HOLD  | serializer held in reset for RST_HOLD enabled cycles
// TRAIN       | TRAIN_WORD sent for TRAIN_WORDS cycles
// DATA        | source words streamed, IDLE_WORD when none accepted
// RESYNC      | 2 TRAIN_WORDs sent, source stalled (macro builds only)

module ser7_link_ctrl #(
   parameter int unsigned RST_HOLD      = 8,
   parameter int unsigned TRAIN_WORDS   = 16,
   parameter logic [6:0]  TRAIN_WORD    = 7'b1010101,
   parameter logic [6:0]  IDLE_WORD     = 7'b0000000,
   parameter int unsigned RESYNC_PERIOD = 1024
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic [6:0]  i_data,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [6:0]  o_din,
   output logic        o_ser_reset,
   output logic        o_trained,
   output logic [1:0]  o_state,
   output logic [15:0] o_sent_cnt
);

   typedef enum logic [1:0] {
      ST_RESET_HOLD = 2'd0,
      ST_TRAIN      = 2'd1,
      ST_DATA       = 2'd2,
      ST_RESYNC     = 2'd3
   } state_t;

   if (RST_HOLD < 1 || RST_HOLD > 255 || TRAIN_WORDS < 1 || TRAIN_WORDS > 255
       || RESYNC_PERIOD < 4 || RESYNC_PERIOD > 65535) begin : g_bad_params
      $error("ser7_link_ctrl: parameter out of range");
   end

   state_t     state;
   logic [7:0] hold_cnt;
   logic [7:0] train_cnt;
   logic       resync_due;

`ifdef SER7_LINK_RESYNC_EN
   logic [15:0] period_cnt;
   logic        rs_cnt;

   // The last cycle of each period is a DATA cycle with ready held low.
   assign resync_due = (period_cnt == 16'(RESYNC_PERIOD - 1));
`else
   assign resync_due = 1'b0;
`endif

   assign o_ready = i_enable && (state == ST_DATA) && !resync_due;
   assign o_state = state;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= ST_RESET_HOLD;
         hold_cnt    <= '0;
         train_cnt   <= '0;
         o_din       <= IDLE_WORD;
         o_ser_reset <= 1'b1;
         o_trained   <= 1'b0;
         o_sent_cnt  <= '0;
`ifdef SER7_LINK_RESYNC_EN
         period_cnt  <= '0;
         rs_cnt      <= 1'b0;
`endif
      end else if (!i_enable) begin
         // The sent count survives an enable drop; only i_reset clears it.
         state       <= ST_RESET_HOLD;
         hold_cnt    <= '0;
         train_cnt   <= '0;
         o_din       <= IDLE_WORD;
         o_ser_reset <= 1'b1;
         o_trained   <= 1'b0;
      end else begin
         case (state)
            ST_RESET_HOLD: begin
               if (hold_cnt == 8'(RST_HOLD - 1)) begin
                  state       <= ST_TRAIN;
                  hold_cnt    <= '0;
                  train_cnt   <= '0;
                  o_ser_reset <= 1'b0;
                  o_din       <= TRAIN_WORD;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            ST_TRAIN: begin
               if (train_cnt == 8'(TRAIN_WORDS - 1)) begin
                  state     <= ST_DATA;
                  train_cnt <= '0;
                  o_din     <= IDLE_WORD;
                  o_trained <= 1'b1;
`ifdef SER7_LINK_RESYNC_EN
                  period_cnt <= '0;
`endif
               end else begin
                  train_cnt <= train_cnt + 8'd1;
                  o_din     <= TRAIN_WORD;
               end
            end
            ST_DATA: begin
               if (o_ready && i_valid) begin
                  o_din      <= i_data;
                  o_sent_cnt <= o_sent_cnt + 16'd1;
               end else begin
                  o_din <= IDLE_WORD;
               end
`ifdef SER7_LINK_RESYNC_EN
               if (resync_due) begin
                  state  <= ST_RESYNC;
                  o_din  <= TRAIN_WORD;
                  rs_cnt <= 1'b0;
               end else begin
                  period_cnt <= period_cnt + 16'd1;
               end
`endif
            end
`ifdef SER7_LINK_RESYNC_EN
            ST_RESYNC: begin
               if (rs_cnt) begin
                  state      <= ST_DATA;
                  o_din      <= IDLE_WORD;
                  period_cnt <= '0;
                  rs_cnt     <= 1'b0;
               end else begin
                  rs_cnt <= 1'b1;
                  o_din  <= TRAIN_WORD;
               end
            end
`endif
            default: begin
               // RESYNC is unreachable without the feature; recover via reset hold.
               state       <= ST_RESET_HOLD;
               hold_cnt    <= '0;
               o_din       <= IDLE_WORD;
               o_ser_reset <= 1'b1;
               o_trained   <= 1'b0;
            end
         endcase
      end
   end

endmodule
